// File: rtl/dff_scan_readback_pkg.sv
// dff_scan_readback_pkg: shared FSM state type and counter sizing for the scan readback block
package dff_scan_readback_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic int cnt_w(input int width, input int parity);
    return $clog2(width + parity + 1);
  endfunction
endpackage

// File: rtl/dff_scan_readback_shreg.sv
// dff_scan_shreg: loadable shift register presenting captured bits plus optional parity in either order
module dff_scan_shreg
  import dff_scan_readback_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LSB_FIRST = 1,
  parameter int PARITY = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             bit_out
);
  localparam int FLEN = WIDTH + PARITY;
  logic [FLEN-1:0] frame;
  logic [FLEN-1:0] sr;
  if (PARITY != 0) begin : g_par
    assign frame = LSB_FIRST != 0 ? {^data, data} : {data, ^data};
  end else begin : g_nopar
    assign frame = data;
  end
  assign bit_out = LSB_FIRST != 0 ? sr[0] : sr[FLEN-1];
  // capture the whole frame at once, then move the presented bit one place per transfer
  always_ff @(posedge clk) begin
    if (clr) sr <= '0;
    else if (load) sr <= frame;
    else if (shift) sr <= LSB_FIRST != 0 ? sr >> 1 : sr << 1;
  end
endmodule

// File: rtl/dff_scan_readback.sv
// dff_scan_readback: captures parallel flop state and streams it out serially with valid/ready handshake
module dff_scan_readback
  import dff_scan_readback_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LSB_FIRST = 1,
  parameter int PARITY = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] cap_data,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             last,
  output logic             done
);
  localparam int FLEN = WIDTH + PARITY;
  localparam int CW = cnt_w(WIDTH, PARITY);
  localparam logic [CW-1:0] LAST_IDX = CW'(FLEN - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic bit_out;
  logic load;
  logic xfer;
  assign load = state == IDLE && start;
  assign xfer = sout_valid && sout_ready;
  assign sout = sout_valid & bit_out;
  dff_scan_shreg #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST), .PARITY(PARITY)) u_shreg (
    .clk(clk),
    .clr(clr),
    .load(load),
    .shift(xfer),
    .data(cap_data),
    .bit_out(bit_out)
  );
  // frame sequencing with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      sout_valid <= 1'b0;
      last <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= SHIFT;
          cnt <= '0;
          busy <= 1'b1;
          sout_valid <= 1'b1;
          last <= LAST_IDX == '0;
        end
        SHIFT: if (sout_ready) begin
          if (cnt == LAST_IDX) begin
            state <= DONE;
            sout_valid <= 1'b0;
            last <= 1'b0;
            done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            last <= cnt + 1'b1 == LAST_IDX;
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dff_scan_readback.sv
// tb_dff_scan_readback: directed and randomized frame checks against a bit-list reference model
module tb_dff_scan_readback;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic [7:0] cap = '0;
  logic ready = 1'b0;
  logic sel = 1'b0;
  logic busy_a, sout_a, valid_a, last_a, done_a;
  logic busy_b, sout_b, valid_b, last_b, done_b;
  logic o_busy, o_sout, o_valid, o_last, o_done;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  dff_scan_readback #(.WIDTH(8), .LSB_FIRST(1), .PARITY(1)) dut_a (
    .clk(clk), .clr(clr), .start(start_a), .cap_data(cap), .busy(busy_a), .sout(sout_a),
    .sout_valid(valid_a), .sout_ready(ready), .last(last_a), .done(done_a)
  );
  dff_scan_readback #(.WIDTH(8), .LSB_FIRST(0), .PARITY(1)) dut_b (
    .clk(clk), .clr(clr), .start(start_b), .cap_data(cap), .busy(busy_b), .sout(sout_b),
    .sout_valid(valid_b), .sout_ready(ready), .last(last_b), .done(done_b)
  );
  assign o_busy = sel ? busy_b : busy_a;
  assign o_sout = sel ? sout_b : sout_a;
  assign o_valid = sel ? valid_b : valid_a;
  assign o_last = sel ? last_b : last_a;
  assign o_done = sel ? done_b : done_a;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else start_a = v;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {31'd0, o_busy}, 0);
    check({tag, "_sout"}, {31'd0, o_sout}, 0);
    check({tag, "_valid"}, {31'd0, o_valid}, 0);
    check({tag, "_last"}, {31'd0, o_last}, 0);
    check({tag, "_done"}, {31'd0, o_done}, 0);
  endtask
  // called at a falling edge; mode 0 always ready, 1 ready pattern 1,0,0,1, 2 random ready
  task automatic frame(input logic [7:0] d, input int mode, input bit inject);
    bit q[$];
    int idx = 0;
    int cyc = 0;
    bit rdy;
    for (int i = 0; i < 8; i++) q.push_back(sel ? d[7-i] : d[i]);
    q.push_back(bit'($countones(d) % 2));
    set_start(1'b1);
    cap = d;
    @(posedge clk);
    #1;
    set_start(1'b0);
    cap = 8'($urandom);
    while (idx < 9 && cyc < 100) begin
      @(negedge clk);
      check("busy", {31'd0, o_busy}, 1);
      check("valid", {31'd0, o_valid}, 1);
      check($sformatf("sout%0d", idx), {31'd0, o_sout}, {31'd0, q[idx]});
      check($sformatf("last%0d", idx), {31'd0, o_last}, {31'd0, idx == 8});
      check("done_early", {31'd0, o_done}, 0);
      rdy = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      ready = rdy;
      set_start(inject && idx == 3);
      cap = inject && idx == 3 ? 8'hFF : 8'($urandom);
      if (rdy) idx++;
      cyc++;
    end
    check("timeout", idx, 9);
    set_start(1'b0);
    @(negedge clk);
    check("done", {31'd0, o_done}, 1);
    check("done_busy", {31'd0, o_busy}, 1);
    check("done_valid", {31'd0, o_valid}, 0);
    check("done_sout", {31'd0, o_sout}, 0);
    ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_idle("after");
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0;
    check_idle("rst_a");
    sel = 1'b1;
    check_idle("rst_b");
    clr = 1'b0;
    sel = 1'b0;
    frame(8'hA5, 0, 1'b0);
    sel = 1'b1;
    frame(8'h07, 0, 1'b0);
    sel = 1'b0;
    frame(8'hA5, 1, 1'b0);
    frame(8'hA5, 0, 1'b1);
    @(negedge clk);
    check_idle("no_requeue");
    ready = 1'b1;
    start_a = 1'b1;
    cap = 8'hA5;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("abort");
    clr = 1'b0;
    frame(8'h3C, 0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      sel = 1'($urandom_range(0, 1));
      frame(8'($urandom), 2, 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dff_scan_readback.md
DFF_SCAN_READBACK -- requirements
Module: dff_scan_readback

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the number of captured flop bits (legal range 1..1024).
REQ-002 The block SHALL have parameter LSB_FIRST, default 1: 1 = bit 0 shifted first, 0 = bit WIDTH-1 first.
REQ-003 The block SHALL have parameter PARITY, default 1: 1 = one even-parity bit appended after the data bits, 0 = none.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, and port clk SHALL be input, 1 bit, the sole clock, all state updating on its rising edge.
REQ-005 Port clr SHALL be input, 1 bit, the reset: synchronous, active-high.
REQ-006 Port start SHALL be input, 1 bit, a capture request.
REQ-007 Port cap_data SHALL be input, WIDTH bits, the parallel flop states to read back.
REQ-008 Port busy SHALL be output, 1 bit, high while a readback is in progress.
REQ-009 Port sout SHALL be output, 1 bit, the serial data bit.
REQ-010 Port sout_valid SHALL be output, 1 bit, meaning sout is valid.
REQ-011 Port sout_ready SHALL be input, 1 bit, the sink's acceptance of the current bit.
REQ-012 Port last SHALL be output, 1 bit, marking the final bit of a frame.
REQ-013 Port done SHALL be output, 1 bit, a one-cycle frame-complete pulse.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE, start=1 at a rising edge SHALL capture cap_data into the shift register, clear the bit counter and move to SHIFT; sout_valid SHALL be 1 in the next cycle, giving 1 cycle latency.
REQ-016 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-017 A bit transfer SHALL occur on an edge where sout_valid=1 and sout_ready=1; the register then advances one position and the counter increments.
REQ-018 While sout_valid=1 and sout_ready=0, sout, sout_valid and last SHALL hold stable.
REQ-019 A frame SHALL be WIDTH+PARITY bits; the parity bit SHALL be the XOR of all captured bits.
REQ-020 last SHALL be 1 exactly while the final bit of a frame is presented.
REQ-021 On transfer of the last bit the FSM SHALL enter DONE; in DONE, done=1, busy=1 and sout_valid=0 for one cycle, then the FSM returns to IDLE unconditionally.
REQ-022 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-023 The bit counter width SHALL be $clog2(WIDTH+PARITY+1) and the counter SHALL never wrap within a frame.
REQ-024 cap_data changes after capture SHALL NOT affect the frame in progress.
REQ-025 sout SHALL be 0 whenever sout_valid=0.

Reset
REQ-026 clr=1 at a rising edge SHALL force IDLE and clear the counter and shift register, taking priority over start and any transfer.
REQ-027 Reset values SHALL be busy=0, sout=0, sout_valid=0, last=0, done=0.
REQ-028 A reset mid-frame SHALL abort the frame with no done pulse; a start on the first edge after clr deasserts SHALL be accepted.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef (IDLE/SHIFT/DONE) and the counter-width computation function.
REQ-030 One sub-module, dff_scan_shreg, SHALL implement the loadable, direction-selectable shift register with parity append; FSM and counter SHALL stay in the top.

Verification
REQ-031 With WIDTH=8, LSB_FIRST=1, PARITY=1, cap_data=8'hA5, start pulse and sout_ready=1, the bench SHALL see sout 1,0,1,0,0,1,0,1,0 on 9 consecutive cycles, last on the 9th, then done=1 for one cycle, then busy=0.
REQ-032 With LSB_FIRST=0, cap_data=8'h07, the bench SHALL see sout 0,0,0,0,0,1,1,1,1 (parity 1).
REQ-033 With sout_ready toggled 1,0,0,1 repeatedly, the bench SHALL see the same bit sequence as REQ-031, with sout and last stable through stall cycles.
REQ-034 A start pulse with cap_data=8'hFF issued mid-frame SHALL leave the frame of 8'hA5 unchanged, with exactly one done pulse.
REQ-035 clr=1 after the 4th transfer SHALL leave all outputs 0 on the next cycle with no done pulse, and a new start with 8'h3C SHALL then produce a complete frame 0,0,1,1,1,1,0,0,0.
